ibex_register_file_cached: RTL
==============================

IBEX_REGISTER_FILE_CACHED -- requirements
Module: ibex_register_file_cached

Interface
REQ-001 SHALL have parameter NumEntries, default 4, number of fully-associative L1 entries (legal 2..16).
REQ-002 SHALL have parameter DataWidth, default 32, register width.
REQ-003 SHALL have parameter RV32E, default 0; 1 = 16 architectural registers, raddr/waddr bit 4 ignored.
REQ-004 SHALL have parameter CntWidth, default 16, width of performance counters.
REQ-005 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port rd_req_i  input  1  read request, held with stable addresses while stall_o=1.
REQ-008 SHALL have ports raddr_a_i, raddr_b_i  input  5  read addresses.
REQ-009 SHALL have ports rdata_a_o, rdata_b_o  output  DataWidth  read data, valid when rvalid_o=1.
REQ-010 SHALL have port rvalid_o  output  1  read data valid this cycle.
REQ-011 SHALL have port stall_o  output  1  request accepted but not yet served.
REQ-012 SHALL have ports we_i (1), waddr_i (5), wdata_i (DataWidth)  inputs  write port.
REQ-013 SHALL have port flush_i  input  1  invalidate all L1 entries.
REQ-014 SHALL have ports hit_cnt_o, miss_cnt_o  output  CntWidth  performance counters.

Function
REQ-015 SHALL hold a backing array of 32 (RV32E: 16) registers and an L1 of NumEntries entries {valid, tag[4:0], data}.
REQ-016 SHALL treat x0 as always-hit reading 0, never allocated, writes to x0 ignored.
REQ-017 SHALL implement FSM states IDLE, FILL_A, FILL_B; reset state IDLE.
REQ-018 IDLE, rd_req_i=1, both operands hit: rvalid_o=1, stall_o=0, rdata combinational from L1, same cycle.
REQ-019 IDLE, rd_req_i=1, any miss: rvalid_o=0, stall_o=1, backing read of first missing address (A before B) issued; next state FILL_A (A missed) or FILL_B (only B missed).
REQ-020 FILL_A: fill data written to victim entry; if B also missed and raddr_b_i != raddr_a_i, issue backing read of B and go FILL_B, else go IDLE.
REQ-021 FILL_B: fill data written to victim entry, go IDLE.
REQ-022 stall_o SHALL be 1 in FILL_A/FILL_B and in the IDLE miss cycle; rvalid_o SHALL be 0 in FILL states.
REQ-023 Latency: single miss -> rvalid_o 2 cycles after request; double distinct miss -> 3 cycles.
REQ-024 Victim SHALL be the first invalid entry (lowest index), else the round-robin pointer entry; pointer advances (mod NumEntries) after each fill into a valid entry, so FILL_B never evicts the FILL_A entry.
REQ-025 Writes SHALL be write-through: backing array always updated; matching valid L1 entry updated same cycle; no allocation on write miss.
REQ-026 Backing read SHALL be write-first: same-cycle write to the read address returns wdata_i.
REQ-027 In a FILL state, we_i=1 with waddr_i equal to fill address SHALL store wdata_i into the filled entry.
REQ-028 In the hit cycle, we_i to a read address SHALL NOT bypass; rdata returns pre-write value.
REQ-029 flush_i=1 SHALL clear all valid bits next edge; in a FILL state it aborts to IDLE without filling; flush wins over a same-cycle fill or write update of L1 (backing write still occurs).
REQ-030 hit_cnt_o SHALL increment on an IDLE cycle with rvalid_o=1 not preceded by stall for that request; miss_cnt_o SHALL increment per completed fill; both saturate at all-ones.
REQ-031 rd_req_i=0 in IDLE SHALL produce rvalid_o=0, stall_o=0, no state change other than writes/flush.

Reset
REQ-032 rst_i=1 SHALL asynchronously clear: all valid bits, tags, L1 data, backing array to 0, pointer 0, FSM IDLE, counters 0; rvalid_o=0, stall_o=0, rdata outputs 0.
REQ-033 Reset asserted mid-FILL SHALL abandon the fill; first post-reset request of any nonzero register misses.

Verification
REQ-034 Reset; write x5=0xDEADBEEF; request A=x5,B=x0 -> stall 2 cycles, rvalid at cycle 2 with 0xDEADBEEF/0; repeat -> rvalid same cycle, hit_cnt_o=1, miss_cnt_o=1.
REQ-035 Request A=x3,B=x4 both cold -> FILL_A, FILL_B, rvalid at cycle 3; miss_cnt_o +2.
REQ-036 NumEntries=4: fill x1..x4, then read x6 -> x1 evicted (pointer 0); read x1 -> miss.
REQ-037 Miss on x7 with we_i x7=0x12345678 in FILL_A cycle -> rdata_a_o=0x12345678 on rvalid.
REQ-038 flush_i during FILL_A of x9 -> IDLE next cycle, all invalid, held request re-misses x9.
REQ-039 Force hit_cnt_o to 0xFFFF (CntWidth 16) via repeated hits -> stays 0xFFFF on further hits.

Source files
------------

// File: rtl/ibex_register_file_cached.sv
// Register file fronted by a small fully-associative L1 cache; misses stall the
// read port while the missing operand(s) are filled from the write-through backing array.
module ibex_register_file_cached #(
  parameter int unsigned NumEntries = 4,
  parameter int unsigned DataWidth  = 32,
  parameter bit          RV32E      = 1'b0,
  parameter int unsigned CntWidth   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rd_req_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
  output logic                 rvalid_o,
  output logic                 stall_o,
  input  logic                 we_i,
  input  logic [4:0]           waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 flush_i,
  output logic [CntWidth-1:0]  hit_cnt_o,
  output logic [CntWidth-1:0]  miss_cnt_o
);

  localparam int unsigned NumRegs = RV32E ? 16 : 32;
  localparam int unsigned AW      = RV32E ? 4 : 5;
  localparam int unsigned PW      = (NumEntries > 1) ? $clog2(NumEntries) : 1;

  typedef enum logic [1:0] {IDLE, FILL_A, FILL_B} state_e;

  state_e                 state_q, state_d;
  logic [NumEntries-1:0]  valid_q, valid_d;
  logic [4:0]             tag_q  [NumEntries];
  logic [4:0]             tag_d  [NumEntries];
  logic [DataWidth-1:0]   data_q [NumEntries];
  logic [DataWidth-1:0]   data_d [NumEntries];
  logic [DataWidth-1:0]   mem_q  [NumRegs];
  logic [PW-1:0]          ptr_q, ptr_d;
  logic                   pend_q, pend_d;
  logic [CntWidth-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CntWidth-1:0]    miss_cnt_q, miss_cnt_d;

  logic [4:0]             addr_a, addr_b, addr_w, fill_addr;
  logic                   we_eff;
  logic                   hit_a, hit_b;
  logic [DataWidth-1:0]   lk_a, lk_b, fill_data;
  logic [PW-1:0]          victim;
  logic                   rvalid, stall;

  function automatic logic [4:0] eff_addr(input logic [4:0] a);
    return RV32E ? {1'b0, a[3:0]} : a;
  endfunction

  assign addr_a = eff_addr(raddr_a_i);
  assign addr_b = eff_addr(raddr_b_i);
  assign addr_w = eff_addr(waddr_i);
  assign we_eff = we_i && (addr_w != '0);

  // L1 lookup; x0 always hits with zero data
  always_comb begin
    hit_a = (addr_a == '0);
    hit_b = (addr_b == '0);
    lk_a  = '0;
    lk_b  = '0;
    for (int unsigned i = 0; i < NumEntries; i++) begin
      if (valid_q[i] && (tag_q[i] == addr_a) && (addr_a != '0)) begin
        hit_a = 1'b1;
        lk_a  = data_q[i];
      end
      if (valid_q[i] && (tag_q[i] == addr_b) && (addr_b != '0)) begin
        hit_b = 1'b1;
        lk_b  = data_q[i];
      end
    end
  end

  // Lowest-index invalid entry, else the round-robin pointer
  always_comb begin
    victim = ptr_q;
    for (int unsigned i = NumEntries; i > 0; i--) begin
      if (!valid_q[i-1]) victim = PW'(i - 1);
    end
  end

  assign fill_addr = (state_q == FILL_B) ? addr_b : addr_a;
  assign fill_data = (we_eff && (addr_w == fill_addr)) ? wdata_i : mem_q[fill_addr[AW-1:0]];

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    ptr_d      = ptr_q;
    pend_d     = pend_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    rvalid     = 1'b0;
    stall      = 1'b0;

    if (we_eff) begin
      for (int unsigned i = 0; i < NumEntries; i++) begin
        if (valid_q[i] && (tag_q[i] == addr_w)) data_d[i] = wdata_i;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (rd_req_i) begin
          if (hit_a && hit_b) begin
            rvalid = 1'b1;
            pend_d = 1'b0;
            if (!pend_q && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + CntWidth'(1);
          end else begin
            stall   = 1'b1;
            pend_d  = 1'b1;
            state_d = !hit_a ? FILL_A : FILL_B;
          end
        end else begin
          pend_d = 1'b0;
        end
      end
      FILL_A, FILL_B: begin
        stall          = 1'b1;
        valid_d[victim] = 1'b1;
        tag_d[victim]   = fill_addr;
        data_d[victim]  = fill_data;
        if (valid_q[victim]) begin
          ptr_d = (ptr_q == PW'(NumEntries - 1)) ? '0 : ptr_q + PW'(1);
        end
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CntWidth'(1);
        state_d = ((state_q == FILL_A) && !hit_b && (addr_b != addr_a)) ? FILL_B : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush also rewinds the pointer: invalid entries then always form a suffix
    // behind it, so a FILL_B can never pick the entry FILL_A just wrote.
    if (flush_i) begin
      valid_d = '0;
      tag_d   = tag_q;
      data_d  = data_q;
      ptr_d   = '0;
      if (state_q != IDLE) begin
        state_d    = IDLE;
        miss_cnt_d = miss_cnt_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      ptr_q      <= '0;
      pend_q     <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int unsigned i = 0; i < NumEntries; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      ptr_q      <= ptr_d;
      pend_q     <= pend_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumRegs; i++) mem_q[i] <= '0;
    end else if (we_eff) begin
      mem_q[addr_w[AW-1:0]] <= wdata_i;
    end
  end

  assign rvalid_o   = rvalid && !rst_i;
  assign stall_o    = stall && !rst_i;
  assign rdata_a_o  = lk_a;
  assign rdata_b_o  = lk_b;
  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule
